// File: rtl/t05_header_serializer_p.sv
// Serializes Huffman header records (LEAF / ZEROS / LEFTS / END) into a bit stream with valid/ready handshake.
// Optional path emission after LEAF records is enabled by defining T05_HDR_PATH_EMIT_EN.
module t05_header_serializer_p #(
    parameter int CHAR_W   = 8,
    parameter int CNT_W    = 8,
    parameter int PATH_MAX = 128,
    parameter int TOT_W    = 16,
    localparam int PL_W    = $clog2(PATH_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_type,
    input  logic [CHAR_W-1:0]   in_char,
    input  logic [CNT_W-1:0]    in_count,
    input  logic [PATH_MAX-1:0] in_path,
    input  logic [PL_W-1:0]     in_path_len,
    output logic                bit_out,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                rec_done,
    output logic                stream_done,
    output logic [TOT_W-1:0]    bits_total
);

    localparam int SH_W = ((CHAR_W > CNT_W) ? CHAR_W : CNT_W) + 1;
    localparam int CW_A = (CNT_W > PL_W) ? CNT_W : PL_W;
    localparam int CW_B = $clog2(SH_W + 1);
    localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;

    localparam logic [1:0] T_LEAF  = 2'b00;
    localparam logic [1:0] T_ZEROS = 2'b01;
    localparam logic [1:0] T_LEFTS = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef T05_HDR_PATH_EMIT_EN
        S_PATH  = 2'd2,
`endif
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              stream_done_q, stream_done_d;
    logic [TOT_W-1:0]  bits_total_q, bits_total_d;
    logic              fire;

`ifdef T05_HDR_PATH_EMIT_EN
    logic                leaf_q, leaf_d;
    logic [PATH_MAX-1:0] path_q, path_d;
    logic [PL_W-1:0]     path_len_q, path_len_d;
`else
    logic unused_path;
    assign unused_path = ^{in_path, in_path_len};
`endif

    assign in_ready    = (state_q == S_IDLE);
    assign rec_done    = (state_q == S_FIN);
    assign stream_done = stream_done_q;
    assign bits_total  = bits_total_q;
    assign fire        = bit_valid && bit_ready;

    always_comb begin
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        if (state_q == S_SHIFT) begin
            bit_valid = 1'b1;
            bit_out   = shift_q[SH_W-1];
        end
`ifdef T05_HDR_PATH_EMIT_EN
        if (state_q == S_PATH) begin
            bit_valid = 1'b1;
            bit_out   = path_q[0];
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        stream_done_d = 1'b0;
        bits_total_d  = bits_total_q;
`ifdef T05_HDR_PATH_EMIT_EN
        leaf_d        = leaf_q;
        path_d        = path_q;
        path_len_d    = path_len_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef T05_HDR_PATH_EMIT_EN
                    leaf_d = 1'b0;
`endif
                    case (in_type)
                        T_LEAF: begin
                            // Marker and character are left-aligned so the MSB always leaves first.
                            shift_d = SH_W'({1'b1, in_char}) << (SH_W - CHAR_W - 1);
                            cnt_d   = CW'(CHAR_W + 1);
                            state_d = S_SHIFT;
`ifdef T05_HDR_PATH_EMIT_EN
                            leaf_d     = 1'b1;
                            path_d     = in_path;
                            path_len_d = (in_path_len > PL_W'(PATH_MAX)) ? PL_W'(PATH_MAX) : in_path_len;
`endif
                        end
                        T_LEFTS: begin
                            if (in_count != '0) begin
                                shift_d = SH_W'({1'b1, in_count}) << (SH_W - CNT_W - 1);
                                cnt_d   = CW'(CNT_W + 1);
                                state_d = S_SHIFT;
                            end else begin
                                state_d = S_FIN;
                            end
                        end
                        T_ZEROS: begin
                            shift_d = '0;
                            cnt_d   = CW'(in_count);
                            state_d = (in_count != '0) ? S_SHIFT : S_FIN;
                        end
                        default: begin
                            stream_done_d = 1'b1;
                            state_d       = S_FIN;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                if (fire) begin
                    shift_d      = shift_q << 1;
                    cnt_d        = cnt_q - CW'(1);
                    bits_total_d = bits_total_q + TOT_W'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIN;
`ifdef T05_HDR_PATH_EMIT_EN
                        if (leaf_q && (path_len_q != '0)) begin
                            state_d = S_PATH;
                            cnt_d   = CW'(path_len_q);
                        end
`endif
                    end
                end
            end
`ifdef T05_HDR_PATH_EMIT_EN
            S_PATH: begin
                if (fire) begin
                    path_d       = path_q >> 1;
                    cnt_d        = cnt_q - CW'(1);
                    bits_total_d = bits_total_q + TOT_W'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            stream_done_q <= 1'b0;
            bits_total_q  <= '0;
`ifdef T05_HDR_PATH_EMIT_EN
            leaf_q        <= 1'b0;
            path_q        <= '0;
            path_len_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            stream_done_q <= stream_done_d;
            bits_total_q  <= bits_total_d;
`ifdef T05_HDR_PATH_EMIT_EN
            leaf_q        <= leaf_d;
            path_q        <= path_d;
            path_len_q    <= path_len_d;
`endif
        end
    end

endmodule

// File: tb/tb_t05_header_serializer_p.sv
// Scoreboard bench for t05_header_serializer_p: directed records, expected bits queued at issue, monitor pops on output.
module tb_t05_header_serializer_p;

    localparam int CHAR_W   = 8;
    localparam int CNT_W    = 8;
    localparam int PATH_MAX = 128;
    localparam int TOT_W    = 16;
    localparam int PL_W     = $clog2(PATH_MAX + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [1:0]          in_type = 2'b00;
    logic [CHAR_W-1:0]   in_char = '0;
    logic [CNT_W-1:0]    in_count = '0;
    logic [PATH_MAX-1:0] in_path = '0;
    logic [PL_W-1:0]     in_path_len = '0;
    logic                bit_out;
    logic                bit_valid;
    logic                bit_ready = 1'b1;
    logic                rec_done;
    logic                stream_done;
    logic [TOT_W-1:0]    bits_total;

    t05_header_serializer_p #(
        .CHAR_W  (CHAR_W),
        .CNT_W   (CNT_W),
        .PATH_MAX(PATH_MAX),
        .TOT_W   (TOT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_char    (in_char),
        .in_count   (in_count),
        .in_path    (in_path),
        .in_path_len(in_path_len),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .rec_done   (rec_done),
        .stream_done(stream_done),
        .bits_total (bits_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];
    int exp_total = 0;
    logic hold_prev = 1'b0;
    logic prev_bit  = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void pop_chk(input string name, input int act);
        int e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got %0d expected nothing (scoreboard empty)", name, act);
        end else begin
            e = exp_q.pop_front();
            chk(name, act, e);
        end
    endfunction

    function automatic int pat_at(input string p, input int i);
        if (i < p.len()) return (p.getc(i) == 8'h31) ? 1 : 0;
        return 1;
    endfunction

    // Monitor: codes 0/1 = data bit, 2 = rec_done, 3 = stream_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_valid", int'(bit_valid), 1);
                chk("hold_bit", int'(bit_out), int'(prev_bit));
            end
            if (bit_valid && bit_ready) pop_chk("bit", int'(bit_out));
            if (stream_done) pop_chk("stream_done", 3);
            if (rec_done) pop_chk("rec_done", 2);
            hold_prev = bit_valid && !bit_ready;
            prev_bit  = bit_out;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send(input string name, input logic [1:0] typ, input logic [7:0] ch,
                        input logic [7:0] cnt, input logic [127:0] path, input logic [7:0] plen,
                        input string exp_bits, input string rdy_pat, input int exp_lat, input bit hold);
        int w;
        int lat;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk({name, " in_ready_timeout"}, int'(in_ready), 1);
            return;
        end
        for (int i = 0; i < exp_bits.len(); i++) exp_q.push_back((exp_bits.getc(i) == 8'h31) ? 1 : 0);
        if (typ == 2'b11) exp_q.push_back(3);
        exp_q.push_back(2);
        in_valid    = 1'b1;
        in_type     = typ;
        in_char     = ch;
        in_count    = cnt;
        in_path     = path;
        in_path_len = plen;
        @(posedge clk);
        #1;
        if (hold) in_type = 2'b11;
        else in_valid = 1'b0;
        bit_ready = pat_at(rdy_pat, 0);
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({name, " in_ready_busy"}, int'(in_ready), 0);
                chk({name, " first_valid"}, int'(bit_valid), (exp_bits.len() > 0) ? 1 : 0);
            end
            if (rec_done) break;
            @(posedge clk);
            #1;
            bit_ready = pat_at(rdy_pat, lat);
        end
        in_valid = 1'b0;
        chk({name, " rec_done_seen"}, int'(rec_done), 1);
        if (exp_lat > 0) chk({name, " latency"}, lat, exp_lat);
        exp_total = (exp_total + exp_bits.len()) % (1 << TOT_W);
        chk({name, " bits_total"}, int'(bits_total), exp_total);
        $display("rec %s type=%0d bits=%0d lat=%0d bits_total=%0d", name, typ, exp_bits.len(), lat, bits_total);
        #1;
        bit_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset bit_valid", int'(bit_valid), 0);
        chk("reset bits_total", int'(bits_total), 0);
        chk("reset rec_done", int'(rec_done), 0);
        chk("reset stream_done", int'(stream_done), 0);

        send("leaf41", 2'b00, 8'h41, 8'd0, '0, 8'd0, "101000001", "", 10, 1'b0);
        send("lefts5", 2'b10, 8'h00, 8'd5, '0, 8'd0, "100000101", "", 10, 1'b1);
        send("lefts0", 2'b10, 8'h00, 8'd0, '0, 8'd0, "", "", 1, 1'b0);
        send("zeros3", 2'b01, 8'h00, 8'd3, '0, 8'd0, "000", "10101", 6, 1'b0);
`ifdef T05_HDR_PATH_EMIT_EN
        send("leaf00_path", 2'b00, 8'h00, 8'd0, 128'b0110, 8'd4, "1000000000110", "", 14, 1'b0);
`else
        send("leaf00_path", 2'b00, 8'h00, 8'd0, 128'b0110, 8'd4, "100000000", "", 10, 1'b0);
`endif
        send("end", 2'b11, 8'h00, 8'd0, '0, 8'd0, "", "", 1, 1'b0);
        send("zeros0", 2'b01, 8'h00, 8'd0, '0, 8'd0, "", "", 1, 1'b0);
        send("leafff_bp", 2'b00, 8'hFF, 8'd0, '0, 8'd0, "111111111", "0011", 12, 1'b0);

        // Reset during the 5th bit of a LEAF: record is abandoned without rec_done.
        @(negedge clk);
        for (int i = 0; i < 9; i++) exp_q.push_back((i == 0 || i == 2 || i == 8) ? 1 : 0);
        exp_q.push_back(2);
        in_valid = 1'b1;
        in_type  = 2'b00;
        in_char  = 8'h41;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_total = 0;
        @(negedge clk);
        chk("midreset bit_valid", int'(bit_valid), 0);
        chk("midreset in_ready", int'(in_ready), 1);
        chk("midreset bits_total", int'(bits_total), 0);
        chk("midreset rec_done", int'(rec_done), 0);
        $display("rec midreset bits_total=%0d in_ready=%0d", bits_total, in_ready);
        repeat (3) @(negedge clk);

        send("leaf41_after", 2'b00, 8'h41, 8'd0, '0, 8'd0, "101000001", "", 10, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
